// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage: stalls the front end while it iterates.
// Optional `MULDIV_FAST_MUL_EN` replaces the 32-cycle multiply with a single-cycle product.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipeline_flush,
  input  logic            ex_invalid_inst,
  input  logic [6:0]      ex_opcode,
  input  logic [6:0]      ex_func7,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [4:0]      ex_wb_rd,
  output logic            md_stall,
  output logic            md_result_valid,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_result_rd
);

  localparam logic [6:0]       OPC_OP     = 7'b0110011;
  localparam logic [6:0]       F7_MULDIV  = 7'b0000001;
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  opa;       // multiplicand / divisor (magnitude)
  logic [XLEN-1:0]  opb;       // multiplier low half / dividend turning into quotient
  logic [XLEN-1:0]  hi;        // product high half / partial remainder
  logic [1:0]       func3_r;
  logic [4:0]       rd_r;
  logic             neg_q;     // sign of product or quotient
  logic             neg_r;     // sign of remainder

  logic            start, is_div, op1_signed, op2_signed, op1_neg, op2_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] abs1, abs2, special_result;

  always_comb begin
    is_div     = ex_func3[2];
    start      = (state == IDLE) && (ex_opcode == OPC_OP) && (ex_func7 == F7_MULDIV) &&
                 !ex_invalid_inst && !pipeline_flush;
    // MULH: both signed, MULHSU: op1 only; DIV/REM signed when func3[0]==0
    op1_signed = is_div ? ~ex_func3[0] : (ex_func3[1:0] == 2'b01 || ex_func3[1:0] == 2'b10);
    op2_signed = is_div ? ~ex_func3[0] : (ex_func3[1:0] == 2'b01);
    op1_neg    = op1_signed & ex_op1[XLEN-1];
    op2_neg    = op2_signed & ex_op2[XLEN-1];
    abs1       = op1_neg ? -ex_op1 : ex_op1;
    abs2       = op2_neg ? -ex_op2 : ex_op2;
    div_zero   = (ex_op2 == '0);
    div_ovf    = ~ex_func3[0] && (ex_op1 == INT_MIN) && (ex_op2 == '1);
    special    = is_div & (div_zero | div_ovf);
    if (ex_func3[1]) special_result = div_zero ? ex_op1 : '0;
    else             special_result = div_zero ? '1 : ex_op1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  logic [XLEN-1:0]   fast_result;

  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
    fast_fix    = (op1_neg ^ op2_neg) ? -fast_prod : fast_prod;
    fast_result = (ex_func3[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
  end
`else
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod, mul_fix;
  logic [XLEN-1:0]   mul_result;

  // Shift-add step; on the last step mul_prod is the full unsigned product.
  always_comb begin
    mul_sum    = {1'b0, hi} + (opb[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
    mul_prod   = {mul_sum, opb[XLEN-1:1]};
    mul_fix    = neg_q ? -mul_prod : mul_prod;
    mul_result = (func3_r == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]   div_shift, div_diff;
  logic            qbit;
  logic [XLEN-1:0] rem_next, quo_next, div_result;

  // Restoring divide step: bring down next dividend bit, subtract if it fits.
  always_comb begin
    div_shift  = {hi, opb[XLEN-1]};
    div_diff   = div_shift - {1'b0, opa};
    qbit       = ~div_diff[XLEN];
    rem_next   = qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_next   = {opb[XLEN-2:0], qbit};
    if (func3_r[1]) div_result = neg_r ? -rem_next : rem_next;
    else            div_result = neg_q ? -quo_next : quo_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_div) state_next = special ? DONE : DIV;
`ifdef MULDIV_FAST_MUL_EN
          else        state_next = DONE;
`else
          else        state_next = MUL;
`endif
        end
      end
      MUL:     if (cnt == LAST_ITER) state_next = DONE;
      DIV:     if (cnt == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (pipeline_flush) state_next = IDLE;
  end

  assign md_stall        = start | (state == MUL) | (state == DIV);
  assign md_result_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      opa          <= '0;
      opb          <= '0;
      hi           <= '0;
      func3_r      <= '0;
      rd_r         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      md_result    <= '0;
      md_result_rd <= '0;
    end else begin
      state <= state_next;
      if (pipeline_flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              func3_r <= ex_func3[1:0];
              rd_r    <= ex_wb_rd;
              neg_q   <= op1_neg ^ op2_neg;
              neg_r   <= op1_neg;
              hi      <= '0;
              cnt     <= '0;
              if (is_div) begin
                opa <= abs2;
                opb <= abs1;
                if (special) begin
                  md_result    <= special_result;
                  md_result_rd <= ex_wb_rd;
                end
              end else begin
                opa <= abs1;
                opb <= abs2;
`ifdef MULDIV_FAST_MUL_EN
                md_result    <= fast_result;
                md_result_rd <= ex_wb_rd;
`endif
              end
            end
          end
`ifdef MULDIV_FAST_MUL_EN
          // Single-cycle multiply never enters the MUL state.
`else
          MUL: begin
            hi  <= mul_sum[XLEN:1];
            opb <= {mul_sum[0], opb[XLEN-1:1]};
            if (cnt == LAST_ITER) begin
              cnt          <= '0;
              md_result    <= mul_result;
              md_result_rd <= rd_r;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          DIV: begin
            hi  <= rem_next;
            opb <= quo_next;
            if (cnt == LAST_ITER) begin
              cnt          <= '0;
              md_result    <= div_result;
              md_result_rd <= rd_r;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipeline_flush = 1'b0;
  logic        ex_invalid_inst = 1'b0;
  logic [6:0]  ex_opcode = 7'b0010011;
  logic [6:0]  ex_func7 = 7'b0;
  logic [2:0]  ex_func3 = 3'b0;
  logic [31:0] ex_op1 = 32'b0;
  logic [31:0] ex_op2 = 32'b0;
  logic [4:0]  ex_wb_rd = 5'b0;
  logic        md_stall, md_result_valid;
  logic [31:0] md_result;
  logic [4:0]  md_result_rd;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush),
    .ex_invalid_inst(ex_invalid_inst), .ex_opcode(ex_opcode), .ex_func7(ex_func7),
    .ex_func3(ex_func3), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_wb_rd(ex_wb_rd),
    .md_stall(md_stall), .md_result_valid(md_result_valid),
    .md_result(md_result), .md_result_rd(md_result_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the driver after each rising edge.
  logic        chk_en = 1'b0, pend = 1'b0, exp_stall = 1'b0, exp_valid = 1'b0;
  logic [31:0] exp_res = 32'b0, hold_res = 32'b0, cap_res = 32'b0;
  logic [4:0]  exp_rd = 5'b0, hold_rd = 5'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'b0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'b0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'b0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'b0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'b0) ? a : a % b;
    endcase
  endfunction

  // Cycle (counting accept as 0) in which the result is presented.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 32'b0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'b0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, md_stall}, {31'b0, exp_stall});
      chk("valid", {31'b0, md_result_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("result", md_result, exp_res);
        chk("result_rd", {27'b0, md_result_rd}, {27'b0, exp_rd});
        cap_res = md_result;
      end else begin
        chk("result_hold", md_result, hold_res);
        chk("rd_hold", {27'b0, md_result_rd}, {27'b0, hold_rd});
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (pend) begin
      hold_res = exp_res;
      hold_rd  = exp_rd;
      pend     = 1'b0;
    end
  endtask

  task automatic drive_idle(input int kind);
    pipeline_flush  = 1'b0;
    ex_invalid_inst = (kind == 1);
    ex_opcode       = (kind == 0) ? 7'b0010011 : 7'b0110011;
    ex_func7        = (kind == 2) ? 7'b0000000 : 7'b0000001;
    ex_func3        = 3'($urandom_range(0, 7));
    ex_op1          = $urandom;
    ex_op2          = $urandom;
    ex_wb_rd        = 5'($urandom_range(0, 31));
  endtask

  task automatic idle(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      drive_idle(kind);
      exp_stall = 1'b0;
      exp_valid = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input int rst_at);
    int lat;
    logic [31:0] r;
    r   = model(f3, a, b);
    lat = model_lat(f3, a, b);
    $display("op func3=%0d op1=%h op2=%h rd=%0d expect=%h latency=%0d flush_at=%0d rst_at=%0d",
             f3, a, b, rd, r, lat, flush_at, rst_at);
    for (int k = 0; k <= lat; k++) begin
      begin_cycle();
      if (k == rst_at) begin
        drive_idle(0);
        rst = 1'b1;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        hold_res  = 32'b0;
        hold_rd   = 5'b0;
        begin_cycle();
        rst = 1'b0;
        drive_idle(0);
        return;
      end
      pipeline_flush  = (k == flush_at);
      ex_invalid_inst = 1'b0;
      ex_opcode       = 7'b0110011;
      ex_func7        = 7'b0000001;
      ex_func3        = f3;
      ex_op1          = a;
      ex_op2          = b;
      ex_wb_rd        = rd;
      exp_stall = (k < lat);
      exp_valid = (k == lat);
      if (k == lat) begin
        exp_res = r;
        exp_rd  = rd;
        pend    = 1'b1;
      end
      if (k == flush_at && k < lat) begin
        begin_cycle();
        drive_idle(0);
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int lat, fa, ra;

    // Pin the reference model to hand-computed values.
    chk("pin_mul", model(3'd0, 32'd7, 32'd6), 32'd42);
    chk("pin_mulh", model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("pin_mulhsu", model(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("pin_div", model(3'd4, -32'd20, 32'd3), 32'hFFFFFFFA);
    chk("pin_rem", model(3'd6, -32'd20, 32'd3), 32'hFFFFFFFE);
    chk("pin_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
    chk("pin_remu", model(3'd7, 32'd100, 32'd7), 32'd2);
    chk("pin_div0", model(3'd4, 32'd55, 32'd0), 32'hFFFFFFFF);
    chk("pin_rem0", model(3'd6, 32'd55, 32'd0), 32'd55);
    chk("pin_ovf", model(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("pin_lat_div0", model_lat(3'd4, 32'd55, 32'd0), 32'd1);
    chk("pin_lat_divu", model_lat(3'd5, 32'd100, 32'd7), 32'd33);

    drive_idle(0);
    begin_cycle();
    chk_en = 1'b1;
    begin_cycle();
    rst = 1'b0;
    idle(3, 0);

    run_op(3'd0, 32'd7, 32'd6, 5'd9, -1, -1);
    idle(1, 0);
    chk("tp_mul_42", cap_res, 32'd42);
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1, -1, -1);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd2, -1, -1);
    run_op(3'd4, -32'd20, 32'd3, 5'd3, -1, -1);
    idle(1, 0);
    chk("tp_div_neg", cap_res, 32'hFFFFFFFA);
    run_op(3'd6, -32'd20, 32'd3, 5'd4, -1, -1);
    run_op(3'd5, 32'd100, 32'd7, 5'd5, -1, -1);
    run_op(3'd7, 32'd100, 32'd7, 5'd6, -1, -1);
    run_op(3'd4, 32'd55, 32'd0, 5'd7, -1, -1);
    run_op(3'd6, 32'd55, 32'd0, 5'd8, -1, -1);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, -1, -1);
    idle(1, 0);
    chk("tp_div_ovf", cap_res, 32'h80000000);

    run_op(3'd5, 32'd1000, 32'd7, 5'd11, 10, -1);
    idle(40, 0);
    run_op(3'd5, 32'd1000, 32'd7, 5'd12, -1, 10);
    idle(5, 0);

    run_op(3'd0, 32'd3, 32'd4, 5'd13, -1, -1);
    run_op(3'd0, 32'd5, 32'd5, 5'd14, -1, -1);
    idle(1, 0);
    chk("tp_b2b_second", cap_res, 32'd25);

    idle(5, 0);
    idle(5, 1);
    idle(5, 2);

    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = rnd_operand();
      b   = rnd_operand();
      lat = model_lat(f3, a, b);
      fa  = -1;
      ra  = -1;
      case ($urandom_range(0, 15))
        0, 1: fa = $urandom_range(1, lat);
        2:    if (lat > 1) ra = $urandom_range(1, lat - 1);
        default: ;
      endcase
      run_op(f3, a, b, 5'($urandom_range(0, 31)), fa, ra);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), $urandom_range(0, 2));
    end

    idle(3, 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
